// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: IRQ_NUM-source prioritised external interrupt controller with an AXI4-Lite register slave.
// Level-triggered gateways by default; defining EXT_IRQ_EDGE_EN switches them to rising-edge capture.
module ext_irq_ctrl #(
  parameter int unsigned IRQ_NUM = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  output logic               ex_trap_valid_o,
  input  logic               ex_trap_ready_i,
  input  logic [31:0]        plic_axi_awaddr,
  input  logic [2:0]         plic_axi_awprot,
  input  logic               plic_axi_awvalid,
  output logic               plic_axi_awready,
  input  logic [31:0]        plic_axi_wdata,
  input  logic [3:0]         plic_axi_wstrb,
  input  logic               plic_axi_wvalid,
  output logic               plic_axi_wready,
  output logic [1:0]         plic_axi_bresp,
  output logic               plic_axi_bvalid,
  input  logic               plic_axi_bready,
  input  logic [31:0]        plic_axi_araddr,
  input  logic [2:0]         plic_axi_arprot,
  input  logic               plic_axi_arvalid,
  output logic               plic_axi_arready,
  output logic [31:0]        plic_axi_rdata,
  output logic [1:0]         plic_axi_rresp,
  output logic               plic_axi_rvalid,
  input  logic               plic_axi_rready
);
  localparam int unsigned IDW      = 5;
  localparam logic [5:0]  PRIO_BEG = 6'd8;
  localparam logic [5:0]  PRIO_END = 6'(8 + IRQ_NUM);

  logic [IRQ_NUM:1]  src, set_req;
  logic [IRQ_NUM:1]  pending_q, pending_d, enable_q, enable_d, in_svc_q, in_svc_d;
  logic [PRIO_W-1:0] thresh_q, thresh_d, best;
  logic [PRIO_W-1:0] prio_q [1:IRQ_NUM];
  logic [PRIO_W-1:0] prio_d [1:IRQ_NUM];
  logic [IDW-1:0]    last_q, last_d, winner, claim_id, cmpl_id;
  logic              valid_q;
  logic              awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q, rword, en_old, en_new;
  logic [5:0]        wa_w, ra_w;
  logic              wr_fire, rd_fire, wa_ok, ra_ok;
  logic              unused_ok;

  function automatic logic addr_ok(input logic [5:0] w);
    return (w <= 6'd4) || (w >= PRIO_BEG && w < PRIO_END);
  endfunction

  assign src     = irq_src_i;
  assign wa_w    = plic_axi_awaddr[7:2];
  assign ra_w    = plic_axi_araddr[7:2];
  assign wa_ok   = addr_ok(wa_w);
  assign ra_ok   = addr_ok(ra_w);
  assign wr_fire = awready_q & plic_axi_awvalid & plic_axi_wvalid;
  assign rd_fire = arready_q & plic_axi_arvalid;

  assign unused_ok = ^{plic_axi_awprot, plic_axi_arprot, plic_axi_awaddr[31:8], plic_axi_awaddr[1:0],
                       plic_axi_araddr[31:8], plic_axi_araddr[1:0], en_new};

`ifdef EXT_IRQ_EDGE_EN
  logic [IRQ_NUM:1] prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= src;
  end
  assign set_req = src & ~prev_q & ~pending_q;
`else
  assign set_req = src & ~in_svc_q & ~pending_q;
`endif

  // Highest priority wins; strict '>' while scanning upward keeps the lowest ID on ties.
  always_comb begin
    winner = '0;
    best   = '0;
    for (int unsigned i = 1; i <= IRQ_NUM; i++) begin
      if (pending_q[i] && enable_q[i] && prio_q[i] > thresh_q && prio_q[i] > best) begin
        best   = prio_q[i];
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    rword = '0;
    case (ra_w)
      6'd0: rword[IRQ_NUM:1]  = pending_q;
      6'd1: rword[IRQ_NUM:1]  = enable_q;
      6'd2: rword[PRIO_W-1:0] = thresh_q;
      6'd3: rword[IDW-1:0]    = winner;
      6'd4: rword[IDW-1:0]    = last_q;
      default: begin
        for (int unsigned i = 1; i <= IRQ_NUM; i++)
          if (ra_w == 6'(7 + i)) rword[PRIO_W-1:0] = prio_q[i];
      end
    endcase
  end

  always_comb begin
    claim_id = (rd_fire && ra_w == 6'd3) ? winner : '0;
    cmpl_id  = (wr_fire && wa_w == 6'd3 && plic_axi_wdata[31:IDW] == '0) ? plic_axi_wdata[IDW-1:0] : '0;
    en_old   = '0;
    en_old[IRQ_NUM:1] = enable_q;
    for (int unsigned b = 0; b < 4; b++)
      en_new[8*b +: 8] = plic_axi_wstrb[b] ? plic_axi_wdata[8*b +: 8] : en_old[8*b +: 8];

    pending_d = pending_q;
    in_svc_d  = in_svc_q;
    enable_d  = enable_q;
    thresh_d  = thresh_q;
    prio_d    = prio_q;
    last_d    = (ex_trap_ready_i && valid_q) ? winner : last_q;

    // A claim and complete of the same ID in one cycle leaves it in service.
    for (int unsigned i = 1; i <= IRQ_NUM; i++) begin
      if (claim_id == IDW'(i)) begin
        pending_d[i] = 1'b0;
        in_svc_d[i]  = 1'b1;
      end else if (cmpl_id == IDW'(i)) begin
        in_svc_d[i]  = 1'b0;
      end
      if (set_req[i]) pending_d[i] = 1'b1;
    end

    if (wr_fire && wa_ok) begin
      if (wa_w == 6'd1) enable_d = en_new[IRQ_NUM:1];
      if (wa_w == 6'd2 && plic_axi_wstrb[0]) thresh_d = plic_axi_wdata[PRIO_W-1:0];
      for (int unsigned i = 1; i <= IRQ_NUM; i++)
        if (wa_w == 6'(7 + i) && plic_axi_wstrb[0]) prio_d[i] = plic_axi_wdata[PRIO_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      enable_q  <= '0;
      in_svc_q  <= '0;
      thresh_q  <= '0;
      last_q    <= '0;
      valid_q   <= 1'b0;
      for (int unsigned i = 1; i <= IRQ_NUM; i++) prio_q[i] <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      in_svc_q  <= in_svc_d;
      thresh_q  <= thresh_d;
      prio_q    <= prio_d;
      last_q    <= last_d;
      valid_q   <= (winner != '0);

      awready_q <= plic_axi_awvalid & plic_axi_wvalid & ~bvalid_q & ~awready_q;
      if (bvalid_q && plic_axi_bready) begin
        bvalid_q <= 1'b0;
      end else if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wa_ok ? 2'b00 : 2'b10;
      end

      arready_q <= plic_axi_arvalid & ~rvalid_q & ~arready_q;
      if (rvalid_q && plic_axi_rready) begin
        rvalid_q <= 1'b0;
      end else if (rd_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ra_ok ? 2'b00 : 2'b10;
        rdata_q  <= ra_ok ? rword : '0;
      end
    end
  end

  assign ex_trap_valid_o  = valid_q;
  assign plic_axi_awready = awready_q;
  assign plic_axi_wready  = awready_q;
  assign plic_axi_bvalid  = bvalid_q;
  assign plic_axi_bresp   = bresp_q;
  assign plic_axi_arready = arready_q;
  assign plic_axi_rvalid  = rvalid_q;
  assign plic_axi_rresp   = rresp_q;
  assign plic_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_ext_irq_ctrl;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_src_i = '0;
  logic          ex_trap_valid_o;
  logic          ex_trap_ready_i = 1'b0;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]    awprot = '0, arprot = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;

  ext_irq_ctrl #(.IRQ_NUM(N), .PRIO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src_i(irq_src_i),
    .ex_trap_valid_o(ex_trap_valid_o), .ex_trap_ready_i(ex_trap_ready_i),
    .plic_axi_awaddr(awaddr), .plic_axi_awprot(awprot), .plic_axi_awvalid(awvalid), .plic_axi_awready(awready),
    .plic_axi_wdata(wdata), .plic_axi_wstrb(wstrb), .plic_axi_wvalid(wvalid), .plic_axi_wready(wready),
    .plic_axi_bresp(bresp), .plic_axi_bvalid(bvalid), .plic_axi_bready(bready),
    .plic_axi_araddr(araddr), .plic_axi_arprot(arprot), .plic_axi_arvalid(arvalid), .plic_axi_arready(arready),
    .plic_axi_rdata(rdata), .plic_axi_rresp(rresp), .plic_axi_rvalid(rvalid), .plic_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: per-ID state arrays updated once per clock.
  bit          m_pend [1:N];
  bit          m_en   [1:N];
  bit          m_svc  [1:N];
  bit          m_prev [1:N];
  int          m_prio [1:N];
  int          m_thr, m_last;
  bit          m_valid;
  logic [31:0] m_rexp;
  logic [1:0]  m_rresp, m_bresp;

  function automatic void m_clear();
    for (int id = 1; id <= N; id++) begin
      m_pend[id] = 0; m_en[id] = 0; m_svc[id] = 0; m_prev[id] = 0; m_prio[id] = 0;
    end
    m_thr = 0; m_last = 0; m_valid = 0;
  endfunction

  // Scan priority levels from the top down; within a level the first (lowest) ID wins.
  function automatic int m_winner();
    for (int p = 7; p > m_thr; p--)
      for (int id = 1; id <= N; id++)
        if (m_pend[id] && m_en[id] && m_prio[id] == p) return id;
    return 0;
  endfunction

  function automatic bit m_addr_ok(input int a);
    return (a < 'h14) || (a >= 'h20 && a < 'h20 + 4 * N);
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int a;
    a = int'(addr[7:0]);
    d = '0;
    r = 2'b00;
    if (!m_addr_ok(a)) begin
      r = 2'b10;
      return;
    end
    case (a)
      'h00: for (int id = 1; id <= N; id++) d[id] = m_pend[id];
      'h04: for (int id = 1; id <= N; id++) d[id] = m_en[id];
      'h08: d = 32'(m_thr);
      'h0C: d = 32'(m_winner());
      'h10: d = 32'(m_last);
      default: d = 32'(m_prio[(a - 'h20) / 4 + 1]);
    endcase
  endfunction

  task automatic tick();
    bit          wr_fire, rd_fire, set;
    int          win, cid, did, a;
    logic [31:0] oldw, mask, neww;
    wr_fire = awvalid && wvalid && awready;
    rd_fire = arvalid && arready;
    win = m_winner();
    cid = 0;
    did = 0;
    if (rd_fire) begin
      m_read(araddr, m_rexp, m_rresp);
      if (araddr[7:0] == 8'h0C) cid = win;
    end
    if (wr_fire && awaddr[7:0] == 8'h0C && wdata >= 1 && wdata <= N) did = int'(wdata);
    for (int id = 1; id <= N; id++) begin
`ifdef EXT_IRQ_EDGE_EN
      set = irq_src_i[id-1] && !m_prev[id] && !m_pend[id];
`else
      set = irq_src_i[id-1] && !m_svc[id] && !m_pend[id];
`endif
      m_prev[id] = irq_src_i[id-1];
      if (did == id) m_svc[id] = 0;
      if (cid == id) begin m_pend[id] = 0; m_svc[id] = 1; end
      if (set) m_pend[id] = 1;
    end
    if (wr_fire) begin
      a = int'(awaddr[7:0]);
      m_bresp = m_addr_ok(a) ? 2'b00 : 2'b10;
      if (a == 'h04) begin
        oldw = '0;
        for (int id = 1; id <= N; id++) oldw[id] = m_en[id];
        mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        neww = (oldw & ~mask) | (wdata & mask);
        for (int id = 1; id <= N; id++) m_en[id] = neww[id];
      end else if (a == 'h08 && wstrb[0]) begin
        m_thr = int'(wdata[2:0]);
      end else if (a >= 'h20 && a < 'h20 + 4 * N && wstrb[0]) begin
        m_prio[(a - 'h20) / 4 + 1] = int'(wdata[2:0]);
      end
    end
    if (ex_trap_ready_i && m_valid) m_last = win;
    m_valid = (win != 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("trap_valid", 32'(ex_trap_valid_o), 32'(m_valid));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    irq_src_i = '0; ex_trap_ready_i = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(ex_trap_valid_o), 32'd0);
    check_eq("rst_rdy", {28'd0, awready, wready, arready, 1'b0}, 32'd0);
    check_eq("rst_bv_rv", {30'd0, bvalid, rvalid}, 32'd0);
    check_eq("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      done = awready;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("aw_handshake", 32'(done), 32'd1);
    for (int k = 0; k < 16 && !bvalid; k++) tick();
    check_eq("bvalid", 32'(bvalid), 32'd1);
    check_eq("bresp", 32'(bresp), 32'(m_bresp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit done = 0;
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      done = arready;
      tick();
    end
    arvalid = 1'b0;
    check_eq("ar_handshake", 32'(done), 32'd1);
    for (int k = 0; k < 16 && !rvalid; k++) tick();
    check_eq("rvalid", 32'(rvalid), 32'd1);
    check_eq("rdata", rdata, m_rexp);
    check_eq("rresp", 32'(rresp), 32'(m_rresp));
    tick();
    check_eq("rdata_hold", rdata, m_rexp);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check_eq(tag, d, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, a;
    logic [1:0]  r;
    int          op;

    do_reset();
    foreach (d[i]) begin end
    rd_expect("rst_pending", 32'h00, 32'd0);
    rd_expect("rst_enable",  32'h04, 32'd0);
    rd_expect("rst_thresh",  32'h08, 32'd0);
    rd_expect("rst_claim",   32'h0C, 32'd0);

    // Priority/threshold gating.
    axi_write(32'h28, 32'd5, 4'hF);
    axi_write(32'h04, 32'h08, 4'hF);
    axi_write(32'h08, 32'd2, 4'hF);
    irq_src_i[2] = 1'b1;
    tick();
    check_eq("gate_lat1", 32'(ex_trap_valid_o), 32'd0);
    tick();
    check_eq("gate_on", 32'(ex_trap_valid_o), 32'd1);
    axi_write(32'h08, 32'd5, 4'hF);
    tick();
    check_eq("gate_off", 32'(ex_trap_valid_o), 32'd0);

    // Winner, tie-break, level re-pend.
    do_reset();
    axi_write(32'h20, 32'd3, 4'hF);
    axi_write(32'h24, 32'd6, 4'hF);
    axi_write(32'h2C, 32'd6, 4'hF);
    axi_write(32'h04, 32'h16, 4'hF);
    irq_src_i = 8'b0000_1011;
    repeat (2) tick();
    rd_expect("claim_a", 32'h0C, 32'd2);
    rd_expect("pend_a",  32'h00, 32'h12);
    rd_expect("claim_b", 32'h0C, 32'd4);
    rd_expect("pend_b",  32'h00, 32'h02);
    rd_expect("claim_c", 32'h0C, 32'd1);
    rd_expect("pend_c",  32'h00, 32'h00);
    repeat (3) tick();
    rd_expect("no_repend", 32'h00, 32'h00);
    axi_write(32'h0C, 32'd2, 4'hF);
    rd_expect("repend", 32'h00, 32'h04);
    axi_write(32'h0C, 32'd9, 4'hF);
    check_eq("cmpl_bad_bresp", 32'(bresp), 32'd0);

    // LAST_TAKEN, strobes and bad address.
    do_reset();
    axi_write(32'h2C, 32'd6, 4'hF);
    axi_write(32'h04, 32'h10, 4'hF);
    irq_src_i = 8'b0000_1000;
    repeat (2) tick();
    ex_trap_ready_i = 1'b1;
    tick();
    ex_trap_ready_i = 1'b0;
    rd_expect("last_taken", 32'h10, 32'd4);
    axi_write(32'h04, 32'hFF, 4'h0);
    axi_write(32'h08, 32'd7, 4'h2);
    rd_expect("strb_en", 32'h04, 32'h10);
    rd_expect("strb_thr", 32'h08, 32'd0);
    axi_read(32'h18, d, r);
    check_eq("bad_rresp", 32'(r), 32'd2);
    check_eq("bad_rdata", d, 32'd0);
    axi_write(32'h18, 32'hFFFF_FFFF, 4'hF);
    check_eq("bad_bresp", 32'(bresp), 32'd2);
    rd_expect("bad_nochg", 32'h04, 32'h10);

`ifdef EXT_IRQ_EDGE_EN
    do_reset();
    axi_write(32'h20, 32'd1, 4'hF);
    axi_write(32'h04, 32'h02, 4'hF);
    irq_src_i[0] = 1'b1;
    repeat (3) tick();
    rd_expect("edge_pend", 32'h00, 32'h02);
    rd_expect("edge_claim", 32'h0C, 32'd1);
    repeat (3) tick();
    rd_expect("edge_norepend", 32'h00, 32'h00);
    irq_src_i[0] = 1'b0;
    tick();
    irq_src_i[0] = 1'b1;
    tick();
    axi_write(32'h0C, 32'd1, 4'hF);
    rd_expect("edge_queued", 32'h00, 32'h02);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(3) == 0) irq_src_i = N'($urandom);
      ex_trap_ready_i = 1'($urandom_range(1));
      op = $urandom_range(15);
      a = 32'($urandom_range(15));
      if (a < 5) a = a * 4;
      else if (a < 13) a = 'h20 + 4 * (a - 5);
      else a = (a == 13) ? 32'h14 : (a == 14) ? 32'h18 : 32'h40;
      if ($urandom_range(3) == 0) a = a | ($urandom << 8);
      if (op < 4) begin
        tick();
      end else if (op < 9) begin
        if (op == 8) a = 32'h0C;
        d = (a[7:0] == 8'h0C) ? 32'($urandom_range(10)) : $urandom;
        axi_write(a, d, 4'($urandom));
      end else begin
        if (op >= 13) a = 32'h0C;
        axi_read(a, d, r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Parametrised multi-channel external interrupt controller.
- Generalises the core's single external interrupt request into IRQ_NUM prioritised sources.
- Drives the core's core_ex_trap_valid / core_ex_trap_ready pair.
- Exposes pending, enable, threshold, priority and claim/complete registers on an AXI4-Lite slave hung off the system bus.

Parameters:
IRQ_NUM, 8, number of interrupt sources, legal range 1..31; source i has ID i+1, ID 0 means "none".
PRIO_W, 3, width of each priority and threshold field; priority 0 means the source never interrupts.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; asynchronous, active-low
irq_src_i  in  IRQ_NUM  interrupt source lines, synchronous to clk
ex_trap_valid_o  in→core  out  1  external interrupt request to core
ex_trap_ready_i  in  1  core has taken the external interrupt
plic_axi_awaddr  in  32  write address
plic_axi_awprot  in  3  ignored
plic_axi_awvalid  in  1  write address valid
plic_axi_awready  out  1  write address ready
plic_axi_wdata  in  32  write data
plic_axi_wstrb  in  4  write strobes
plic_axi_wvalid  in  1  write data valid
plic_axi_wready  out  1  write data ready
plic_axi_bresp  out  2  write response
plic_axi_bvalid  out  1  write response valid
plic_axi_bready  in  1  write response ready
plic_axi_araddr  in  32  read address
plic_axi_arprot  in  3  ignored
plic_axi_arvalid  in  1  read address valid
plic_axi_arready  out  1  read address ready
plic_axi_rdata  out  32  read data
plic_axi_rresp  out  2  read response
plic_axi_rvalid  out  1  read data valid
plic_axi_rready  in  1  read data ready

Behaviour:
- Register map (addr[7:0], word aligned):
  - 0x00 PENDING: RO; bit ID = pending.
  - 0x04 ENABLE: RW; bit ID.
  - 0x08 THRESHOLD: RW, PRIO_W bits.
  - 0x0C CLAIM: read = claim, write = complete.
  - 0x10 LAST_TAKEN: RO.
  - 0x20+4*(ID-1) PRIORITY[ID]: RW, PRIO_W bits.
  - Bit 0 of PENDING/ENABLE reads 0 and is not writable.
  - Unused bits read 0.
  - Any other address returns SLVERR (2'b10), read data 0, no side effect.
- Byte strobes: honoured on ENABLE; THRESHOLD/PRIORITY take write only if wstrb[0].
- Reset:
  - All registers 0.
  - ex_trap_valid_o = 0.
  - All *ready, bvalid, rvalid = 0.
  - bresp/rresp/rdata = 0.
  - Reset mid-transaction aborts it silently.
- Gateway per source, level mode:
  - pending[ID] sets when src high, in_service[ID]=0 and pending[ID]=0.
  - Claim clears pending[ID] and sets in_service[ID].
  - Complete write of ID clears in_service[ID].
  - Complete of an ID not in service, or ID 0 / ID > IRQ_NUM: ignored, bresp OKAY.
- Arbitration (combinational):
  - Candidate = pending & enable & (priority > threshold).
  - Winner = highest priority; ties go to lowest ID; no candidate → ID 0.
- Core request:
  - ex_trap_valid_o is registered: next = (winner != 0).
  - Latency from irq_src_i rise to ex_trap_valid_o high: 2 cycles (pending reg + valid reg).
  - valid stays high until no candidate remains; it is not cleared by ready.
  - ex_trap_ready_i & ex_trap_valid_o in the same cycle latches winner ID into LAST_TAKEN.
- CLAIM read:
  - At AR accept, returns current winner ID and performs the claim atomically.
  - Winner 0 → returns 0, no state change.
- AXI write channel:
  - One outstanding transaction.
  - awready = wready = 1 for exactly one cycle when awvalid & wvalid & !bvalid.
  - bvalid rises the next cycle and holds until bready.
  - AW without W, or W without AW, waits.
- AXI read channel:
  - arready pulses one cycle when arvalid & !rvalid.
  - rvalid/rdata appear the next cycle and hold stable until rready.
- Simultaneous events:
  - Claim and complete of the same ID in one cycle: claim wins, in_service stays 1.
  - Claim and complete of different IDs: both applied.
  - Register write to ENABLE/PRIORITY takes effect on arbitration the cycle after B is issued.
  - Source held high across complete: pending re-sets the cycle after complete.

Optional Feature:
- Macro EXT_IRQ_EDGE_EN.
- Defined:
  - Each source has a registered previous-value flop.
  - A rising edge (prev=0, cur=1) sets pending[ID] regardless of in_service.
  - An edge while already pending is lost.
  - Edges while in service queue exactly one pending.
- Undefined: pure level gateway as above; no edge flops are synthesised.

Test Plan:
- Reset, read 0x00/0x04/0x08/0x0C → all 0, rresp OKAY; ex_trap_valid_o=0.
- Priority/threshold gating:
  - Setup: PRIORITY[3]=5, ENABLE=0x08, THRESHOLD=2; raise irq_src_i[2].
  - Required: ex_trap_valid_o=1 two cycles later.
  - Then: THRESHOLD=5 → valid falls.
- Winner and tie-break:
  - Setup: IDs 1,2,4 enabled with priorities 3,6,6, all asserted.
  - Required: CLAIM read returns 2, then 4, then 1; PENDING bit cleared on each claim.
- Level re-pend:
  - Setup: claim ID 2 with source held high.
  - Required: no re-pend until complete write 2; PENDING[2]=1 the cycle after complete.
- LAST_TAKEN and bad address:
  - Pulse ex_trap_ready_i while winner=4 → LAST_TAKEN reads 4.
  - Access to 0x18 → SLVERR, no state change.
- Edge mode (EXT_IRQ_EDGE_EN):
  - Setup: hold source 1 high.
  - Required: one pending only; after claim, no re-pend; a toggle 0→1 while in service pends once after complete.
